// File: rtl/stall_ctrl.sv
// Pipeline hazard detector: tracks per-stage writer info for E/M/W and the
// multiply/divide occupancy, and raises stall on RAW or MDU-busy hazards.
module stall_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_D,
  input  logic [4:0] rt_D,
  input  logic [1:0] tuse_rs_D,
  input  logic [1:0] tuse_rt_D,
  input  logic [4:0] a3_D,
  input  logic       rwe_D,
  input  logic [1:0] tnew_D,
  input  logic       md_start_D,
  input  logic       md_div_D,
  input  logic       md_use_D,
  input  logic       flush,
  output logic       stall,
  output logic [4:0] A3_E,
  output logic [4:0] A3_M,
  output logic [4:0] A3_W,
  output logic       RWE_E,
  output logic       RWE_M,
  output logic       RWE_W,
  output logic       md_busy
);

  localparam logic [1:0] TUSE_NONE = 2'd3;
  localparam logic [3:0] MUL_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES = 4'd10;

  logic [1:0] tnew_e;
  logic [1:0] tnew_m;
  logic       md_start_e;
  logic       md_div_e;
  logic [3:0] md_cnt;

  logic       hazard_rs;
  logic       hazard_rt;
  logic       hazard_md;

  // True when one stage's writer produces src later than D needs it.
  function automatic logic stage_hit(input logic [4:0] src, input logic [1:0] tuse,
                                     input logic rwe, input logic [4:0] a3,
                                     input logic [1:0] tnew);
    return rwe && (src == a3) && (tnew > tuse);
  endfunction

  // Register 0 and unused operands never wait; W is always forwardable.
  assign hazard_rs = (rs_D != 5'd0) && (tuse_rs_D != TUSE_NONE) &&
                     (stage_hit(rs_D, tuse_rs_D, RWE_E, A3_E, tnew_e) ||
                      stage_hit(rs_D, tuse_rs_D, RWE_M, A3_M, tnew_m));
  assign hazard_rt = (rt_D != 5'd0) && (tuse_rt_D != TUSE_NONE) &&
                     (stage_hit(rt_D, tuse_rt_D, RWE_E, A3_E, tnew_e) ||
                      stage_hit(rt_D, tuse_rt_D, RWE_M, A3_M, tnew_m));

  assign md_busy   = md_start_e || (md_cnt != 4'd0);
  assign hazard_md = (md_use_D || md_start_D) && md_busy;
  assign stall     = hazard_rs || hazard_rt || hazard_md;

  // NOTE: all state below uses non-blocking assignments so every stage samples
  // the pre-edge value of the stage ahead of it, exactly like pipeline latches.
  always_ff @(posedge clk) begin
    if (reset) begin
      A3_E       <= 5'd0;
      RWE_E      <= 1'b0;
      tnew_e     <= 2'd0;
      A3_M       <= 5'd0;
      RWE_M      <= 1'b0;
      tnew_m     <= 2'd0;
      A3_W       <= 5'd0;
      RWE_W      <= 1'b0;
      md_start_e <= 1'b0;
      md_div_e   <= 1'b0;
    end else if (flush) begin
      A3_E       <= 5'd0;
      RWE_E      <= 1'b0;
      tnew_e     <= 2'd0;
      A3_M       <= 5'd0;
      RWE_M      <= 1'b0;
      tnew_m     <= 2'd0;
      A3_W       <= 5'd0;
      RWE_W      <= 1'b0;
      md_start_e <= 1'b0;
      md_div_e   <= 1'b0;
    end else begin
      A3_W  <= A3_M;
      RWE_W <= RWE_M;
      A3_M  <= A3_E;
      RWE_M <= RWE_E;
      tnew_m <= (tnew_e == 2'd0) ? 2'd0 : tnew_e - 2'd1;
      if (stall) begin
        A3_E   <= 5'd0;
        RWE_E  <= 1'b0;
        tnew_e <= 2'd0;
      end else begin
        A3_E   <= a3_D;
        RWE_E  <= rwe_D && (a3_D != 5'd0);
        tnew_e <= tnew_D;
      end
      md_start_e <= md_start_D && !stall;
      md_div_e   <= md_div_D;
    end
  end

  // A started operation runs to completion regardless of flush.
  always_ff @(posedge clk) begin
    if (reset)
      md_cnt <= 4'd0;
    else if (md_start_e)
      md_cnt <= md_div_e ? DIV_CYCLES : MUL_CYCLES;
    else if (md_cnt != 4'd0)
      md_cnt <= md_cnt - 4'd1;
  end

endmodule
